// File: rtl/oled_cmd_sequencer.sv
// OLED front-end: panel reset timing, init table burst, runtime commands.
// Ports: i_clk/i_rst_n, init/cmd handshake, panel reset, i2c_master side.
module oled_cmd_sequencer #(
  parameter logic [9:0] DEV_ADDR = 10'h03C,
  parameter int NUM_INIT         = 4,
  parameter int RST_PULSE_CYCLES = 1_000_000,
  parameter int RST_WAIT_CYCLES  = 1_000_000,
  parameter int MAX_RETRIES      = 2,
  parameter int AUTO_INIT        = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_init,
  input  logic [8*NUM_INIT-1:0] i_init_table,
  input  logic                  i_cmd_valid,
  input  logic [7:0]            i_cmd_byte,
  output logic                  o_cmd_ready,
  output logic                  o_oled_rst_n,
  output logic                  o_init_done,
  output logic                  o_busy,
  output logic                  o_error,
  output logic [9:0]            o_slave_addr,
  output logic [7:0]            o_byte_cnt,
  output logic [3:0]            o_control_reg,
  output logic [3:0]            o_mode_reg,
  output logic [7:0]            o_tx_data,
  input  logic                  i_tx_data_needed,
  input  logic [4:0]            i_status_reg
);

  localparam int CMAX = (RST_PULSE_CYCLES > RST_WAIT_CYCLES)
                      ? RST_PULSE_CYCLES : RST_WAIT_CYCLES;
  localparam int CW = (CMAX < 1) ? 1 : $clog2(CMAX + 1);
  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] P_LAST = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] W_LAST = CW'(RST_WAIT_CYCLES - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRIES);
  localparam logic [7:0]    INIT_CNT = 8'(NUM_INIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_LOW,
    S_RST_WAIT,
    S_XFER_START,
    S_XFER,
    S_ERROR
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [RW-1:0]   retries;
  logic [7:0]      idx;
  logic            mode_cmd;
  logic [7:0]      cmd_q;
  logic            auto_pend;
  logic [7:0]      next_byte;
  logic            start_req;
  logic            unused_status;

  assign o_slave_addr  = DEV_ADDR;
  assign o_mode_reg    = 4'b0000;
  assign unused_status = ^{i_status_reg[4], i_status_reg[1:0]};

  // Reset release counts as an init request when AUTO_INIT is set.
  assign start_req = i_init | auto_pend;

  // Payload byte for the current index; past the end it reads as 0.
  always_comb begin
    next_byte = 8'h00;
    if (mode_cmd) begin
      if (idx == 8'd0) next_byte = cmd_q;
    end else begin
      for (int k = 0; k < NUM_INIT; k++)
        if (idx == 8'(k)) next_byte = i_init_table[8*k +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      retries       <= '0;
      idx           <= 8'd0;
      mode_cmd      <= 1'b0;
      cmd_q         <= 8'h00;
      auto_pend     <= (AUTO_INIT != 0);
      o_cmd_ready   <= 1'b0;
      o_oled_rst_n  <= 1'b1;
      o_init_done   <= 1'b0;
      o_busy        <= 1'b0;
      o_error       <= 1'b0;
      o_byte_cnt    <= 8'd0;
      o_control_reg <= 4'b0000;
      o_tx_data     <= 8'h00;
    end else begin
      auto_pend <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_req) begin
            state        <= S_RST_LOW;
            o_oled_rst_n <= 1'b0;
            o_init_done  <= 1'b0;
            o_cmd_ready  <= 1'b0;
            o_busy       <= 1'b1;
            cnt          <= '0;
            retries      <= '0;
          end else if (i_cmd_valid && o_cmd_ready) begin
            state         <= S_XFER_START;
            cmd_q         <= i_cmd_byte;
            mode_cmd      <= 1'b1;
            o_cmd_ready   <= 1'b0;
            o_busy        <= 1'b1;
            retries       <= '0;
            o_control_reg <= 4'b1000;
            o_tx_data     <= 8'h00;
            o_byte_cnt    <= 8'd2;
          end
        end
        S_RST_LOW: begin
          if (cnt == P_LAST) begin
            state        <= S_RST_WAIT;
            o_oled_rst_n <= 1'b1;
            cnt          <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RST_WAIT: begin
          if (cnt == W_LAST) begin
            state         <= S_XFER_START;
            mode_cmd      <= 1'b0;
            retries       <= '0;
            o_control_reg <= 4'b1000;
            o_tx_data     <= 8'h00;
            o_byte_cnt    <= INIT_CNT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_XFER_START: begin
          state         <= S_XFER;
          o_control_reg <= 4'b0000;
          idx           <= 8'd0;
        end
        S_XFER: begin
          if (i_status_reg[3]) begin
            if (!i_status_reg[2]) begin
              // Commands are only taken once init is done,
              // so any clean finish leaves init done.
              state       <= S_IDLE;
              o_busy      <= 1'b0;
              o_init_done <= 1'b1;
              o_cmd_ready <= 1'b1;
            end else if (retries < R_MAX) begin
              state         <= S_XFER_START;
              retries       <= retries + 1'b1;
              o_control_reg <= 4'b1000;
              o_tx_data     <= 8'h00;
            end else begin
              state   <= S_ERROR;
              o_busy  <= 1'b0;
              o_error <= 1'b1;
            end
          end else if (i_tx_data_needed) begin
            o_tx_data <= next_byte;
            if (idx != 8'hFF) idx <= idx + 8'd1;
          end
        end
        S_ERROR: begin
          if (i_init) begin
            state        <= S_RST_LOW;
            o_error      <= 1'b0;
            o_init_done  <= 1'b0;
            o_oled_rst_n <= 1'b0;
            o_busy       <= 1'b1;
            cnt          <= '0;
            retries      <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_cmd_sequencer.sv
// Bench for oled_cmd_sequencer: timeline model plus per-cycle compare.
// Directed init, command, NACK/retry, error, and mid-transfer reset.
module tb_oled_cmd_sequencer;

  localparam int NI = 3;
  localparam int P  = 20;
  localparam int W  = 10;
  localparam int MR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            init;
  logic [8*NI-1:0] table_v = {8'hA5, 8'hAF, 8'hAE};
  logic            cmd_valid;
  logic [7:0]      cmd_byte;
  logic            tx_need;
  logic [4:0]      status;

  logic       cmd_ready, oled_rst_n, init_done, busy, err;
  logic [9:0] slave_addr;
  logic [7:0] byte_cnt, tx_data;
  logic [3:0] ctrl, mode;

  oled_cmd_sequencer #(
    .DEV_ADDR(10'h03C), .NUM_INIT(NI),
    .RST_PULSE_CYCLES(P), .RST_WAIT_CYCLES(W),
    .MAX_RETRIES(MR), .AUTO_INIT(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_init(init),
    .i_init_table(table_v),
    .i_cmd_valid(cmd_valid), .i_cmd_byte(cmd_byte),
    .o_cmd_ready(cmd_ready), .o_oled_rst_n(oled_rst_n),
    .o_init_done(init_done), .o_busy(busy), .o_error(err),
    .o_slave_addr(slave_addr), .o_byte_cnt(byte_cnt),
    .o_control_reg(ctrl), .o_mode_reg(mode),
    .o_tx_data(tx_data),
    .i_tx_data_needed(tx_need), .i_status_reg(status)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Expected outputs, set by the scenario from the timing rules.
  logic       m_rst_n, m_done, m_busy, m_err, m_ready;
  logic [3:0] m_ctrl;
  logic [7:0] m_cnt, m_tx, m_cmd;
  int         m_retry;
  bit         m_cmd_mode;
  int         m_next;
  bit         chk_en = 1'b0;

  logic [7:0] tbl_q[$] = '{8'hAE, 8'hAF, 8'hA5};
  logic [7:0] got_q[$];
  int low_cnt   = 0;
  int start_cnt = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!oled_rst_n) low_cnt++;
    if (ctrl == 4'b1000) start_cnt++;
    if (chk_en) begin
      chk("oled_rst_n", oled_rst_n, m_rst_n);
      chk("init_done", init_done, m_done);
      chk("busy", busy, m_busy);
      chk("error", err, m_err);
      chk("cmd_ready", cmd_ready, m_ready);
      chk("control_reg", ctrl, m_ctrl);
      chk("byte_cnt", byte_cnt, m_cnt);
      chk("tx_data", tx_data, m_tx);
      chk("slave_addr", slave_addr, 10'h03C);
      chk("mode_reg", mode, 4'b0000);
    end
  end

  function automatic logic [7:0] payload(int k);
    logic [7:0] r;
    r = 8'h00;
    if (m_cmd_mode) begin
      if (k == 0) r = m_cmd;
    end else if (k < tbl_q.size()) begin
      r = tbl_q[k];
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model();
    m_rst_n = 1'b1; m_done = 1'b0; m_busy = 1'b0;
    m_err = 1'b0; m_ready = 1'b0; m_ctrl = 4'd0;
    m_cnt = 8'd0; m_tx = 8'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; init = 1'b0; cmd_valid = 1'b0;
    cmd_byte = 8'h00; tx_need = 1'b0; status = 5'd0;
    step();
    reset_model();
    chk_en = 1'b1;
    step();
    chk("lit_rst_oled", oled_rst_n, 1'b1);
    chk("lit_rst_busy", busy, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic enter_rst_low();
    m_rst_n = 1'b0; m_busy = 1'b1; m_done = 1'b0;
    m_err = 1'b0; m_ready = 1'b0; m_retry = 0;
  endtask

  task automatic start_model(bit cmd);
    m_cmd_mode = cmd;
    m_ctrl = 4'b1000;
    m_tx = 8'h00;
    m_cnt = cmd ? 8'd2 : 8'(NI + 1);
    m_next = 0;
  endtask

  // Called just after the edge that drove the panel reset low.
  task automatic run_reset_phase();
    low_cnt = 0;
    repeat (P - 1) step();
    step();
    m_rst_n = 1'b1;
    repeat (W - 1) step();
    step();
    start_model(1'b0);
    chk("lit_low_cycles", low_cnt, P);
  endtask

  task automatic enter_xfer();
    step();
    m_ctrl = 4'd0;
  endtask

  task automatic serve(int n);
    repeat (n) begin
      tx_need = 1'b1;
      step();
      tx_need = 1'b0;
      m_tx = payload(m_next);
      m_next++;
      got_q.push_back(tx_data);
      step();
    end
  endtask

  task automatic finish(bit nack);
    status = nack ? 5'b01100 : 5'b01000;
    step();
    status = 5'd0;
    if (!nack) begin
      m_busy = 1'b0; m_done = 1'b1; m_ready = 1'b1;
    end else if (m_retry < MR) begin
      m_retry++;
      start_model(m_cmd_mode);
      step();
      m_ctrl = 4'd0;
    end else begin
      m_busy = 1'b0; m_err = 1'b1; m_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Auto init after reset release, extra byte, ignored init.
    do_reset();
    step();
    enter_rst_low();
    run_reset_phase();
    chk("lit_init_bytecnt", byte_cnt, 8'd4);
    chk("lit_init_start", ctrl, 4'b1000);
    enter_xfer();
    init = 1'b1;
    step();
    init = 1'b0;
    got_q.delete();
    serve(4);
    chk("lit_byte1", got_q[0], 8'hAE);
    chk("lit_byte2", got_q[1], 8'hAF);
    chk("lit_byte3", got_q[2], 8'hA5);
    chk("lit_extra", got_q[3], 8'h00);
    finish(1'b0);
    chk("lit_init_done", init_done, 1'b1);

    // Runtime command.
    step();
    chk("lit_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_byte = 8'hA4;
    m_cmd = 8'hA4;
    step();
    cmd_valid = 1'b0;
    m_busy = 1'b1; m_ready = 1'b0; m_retry = 0;
    start_model(1'b1);
    chk("lit_cmd_bytecnt", byte_cnt, 8'd2);
    enter_xfer();
    got_q.delete();
    serve(2);
    chk("lit_cmd_byte", got_q[0], 8'hA4);
    chk("lit_cmd_extra", got_q[1], 8'h00);
    finish(1'b0);
    chk("lit_cmd_busy", busy, 1'b0);

    // Single NACK then success.
    do_reset();
    start_cnt = 0;
    step();
    enter_rst_low();
    run_reset_phase();
    enter_xfer();
    serve(3);
    finish(1'b1);
    serve(3);
    finish(1'b0);
    chk("lit_two_starts", start_cnt, 2);
    chk("lit_nack_err", err, 1'b0);
    chk("lit_nack_done", init_done, 1'b1);

    // Persistent NACK, error, recovery, mid-transfer reset.
    do_reset();
    step();
    enter_rst_low();
    run_reset_phase();
    enter_xfer();
    serve(1);
    finish(1'b1);
    serve(2);
    finish(1'b1);
    finish(1'b1);
    chk("lit_error", err, 1'b1);
    cmd_valid = 1'b1;
    cmd_byte = 8'h55;
    repeat (3) step();
    cmd_valid = 1'b0;
    init = 1'b1;
    step();
    init = 1'b0;
    enter_rst_low();
    chk("lit_err_clr", err, 1'b0);
    run_reset_phase();
    enter_xfer();
    serve(2);
    rst_n = 1'b0;
    step();
    reset_model();
    chk("lit_mid_busy", busy, 1'b0);
    chk("lit_mid_tx", tx_data, 8'h00);
    rst_n = 1'b1;
    step();
    enter_rst_low();
    repeat (3) step();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/oled_cmd_sequencer.md
Name: oled_cmd_sequencer

Overview:
- Parametrised OLED controller front-end; successor to the single-sequence OLED demo controller.
- Drives the panel hardware reset pin with programmable timing.
- Streams a configurable init command table to the panel as one I2C write transaction, then accepts runtime single commands over a valid/ready handshake.
- Sits between user logic and the i2c_master core, adding NACK retry and an error flag.

Parameters:
- DEV_ADDR, 10'h03C, I2C slave address driven on o_slave_addr.
- NUM_INIT, 4, number of command bytes in the init table (1..254).
- RST_PULSE_CYCLES, 1_000_000, clock cycles o_oled_rst_n is held low (10 ms at 100 MHz).
- RST_WAIT_CYCLES, 1_000_000, cycles to wait after reset release before the first I2C transfer.
- MAX_RETRIES, 2, re-attempts of a NACKed transaction before entering ERROR (0..15).
- AUTO_INIT, 1, 1 = start the reset/init sequence automatically after i_rst_n deasserts.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_init  in  1  one-cycle pulse; starts the reset/init sequence (honoured in IDLE or ERROR only).
- i_init_table  in  8*NUM_INIT  init commands; byte k = bits [8k+7:8k]; byte 0 is sent first.
- i_cmd_valid  in  1  runtime command valid.
- i_cmd_byte  in  8  runtime command byte.
- o_cmd_ready  out  1  high only in IDLE with o_init_done=1.
- o_oled_rst_n  out  1  panel reset, active low.
- o_init_done  out  1  set when the init transaction completes; cleared on reset or i_init.
- o_busy  out  1  high in every state except IDLE and ERROR.
- o_error  out  1  high in ERROR.
- o_slave_addr  out  10  to i2c_master; constant DEV_ADDR.
- o_byte_cnt  out  8  to i2c_master; total bytes in the transaction.
- o_control_reg  out  4  to i2c_master; bit3 = start, one-cycle pulse; other bits 0.
- o_mode_reg  out  4  to i2c_master; always 4'b0000 (write).
- o_tx_data  out  8  to i2c_master; current tx byte.
- i_tx_data_needed  in  1  from i2c_master; one-cycle pulse requesting the next byte.
- i_status_reg  in  5  from i2c_master; bit3 = transaction done (pulse), bit2 = NACK (pulse, coincides with bit3).

Behaviour:
- Reset (i_rst_n=0 at the clock edge) values:
  - o_oled_rst_n=1; o_init_done=0; o_busy=0; o_error=0; o_cmd_ready=0.
  - o_control_reg=0; o_byte_cnt=0; o_tx_data=0.
  - All counters = 0; state = IDLE.
  - With AUTO_INIT=1, the first cycle after release behaves as if i_init were pulsed.
- States: IDLE, RST_LOW, RST_WAIT, XFER_START, XFER, ERROR.
- IDLE:
  - i_init → RST_LOW, o_init_done←0, retry count←0.
  - Else i_cmd_valid & o_cmd_ready → latch i_cmd_byte, mode=CMD, → XFER_START. The handshake completes in that cycle.
- RST_LOW:
  - o_oled_rst_n=0 for exactly RST_PULSE_CYCLES cycles, then → RST_WAIT.
- RST_WAIT:
  - o_oled_rst_n=1 for RST_WAIT_CYCLES cycles, then mode=INIT, → XFER_START.
- XFER_START (one cycle):
  - o_control_reg=4'b1000.
  - o_tx_data=8'h00 (the SSD1306 command control byte).
  - o_byte_cnt = NUM_INIT+1 in INIT mode, 2 in CMD mode.
  - Byte index←0; → XFER.
- XFER:
  - o_control_reg=0.
  - On each i_tx_data_needed pulse, o_tx_data updates on the next edge to the next payload byte: init table byte idx, or the latched command.
  - After the payload is exhausted, further requests return 8'h00.
- Completion, on i_status_reg[3]:
  - If bit2=0: INIT mode → o_init_done←1; → IDLE.
  - If bit2=1 and retries<MAX_RETRIES: retries+1, → XFER_START. The whole transaction is resent, starting with the control byte.
  - If bit2=1 and retries exhausted: → ERROR.
- ERROR:
  - o_error=1; o_cmd_ready=0.
  - i_init → RST_LOW and clears o_error.
  - i_cmd_valid is ignored.
- Retry count is cleared on every entry to XFER_START from IDLE/RST_WAIT.
- i_init outside IDLE/ERROR is ignored and not queued.
- i_cmd_valid during the init sequence: ready stays 0 and the command waits; the producer must hold valid.
- Synchronous reset mid-transfer returns to IDLE immediately. Start is not re-asserted.
- Counter widths: $clog2(max+1).
- NUM_INIT+1 must fit in 8 bits.

Test Plan:
- Sim parameters RST_PULSE_CYCLES=20, RST_WAIT_CYCLES=10, NUM_INIT=3, table {8'hA5,8'hAF,8'hAE}, AUTO_INIT=1.
  - Release i_rst_n → o_oled_rst_n low exactly 20 cycles.
  - 10 cycles later, a start pulse with o_byte_cnt=4.
  - Bytes issued 00,AE,AF,A5; o_init_done=1 after done.
- Same setup, then runtime command: i_cmd_valid with 8'hA4 in IDLE → one-cycle handshake, byte_cnt=2, tx bytes 00,A4, o_busy returns to 0 after done.
- Single NACK: NACK (status bits 3,2) on the first init attempt with MAX_RETRIES=2 → second start pulse, full resend from 00, success → o_init_done=1, o_error=0.
- Persistent NACK: NACK on 3 consecutive attempts → o_error=1 after the third; i_cmd_valid ignored; i_init restarts RST_LOW and clears o_error.
- Extra byte request: one extra i_tx_data_needed after the last payload byte → o_tx_data=8'h00.
- Reset mid-transfer: i_rst_n low during XFER → all outputs at reset values next cycle.
- Ignored init: i_init pulsed during XFER → no effect.
